// File: rtl/wr_data_path_pkg.sv
// Shared types and constants for the DDR5 PHY write data path.
// The DQS sequencer state and the fixed DQS pair encodings live here.
package wr_data_path_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StBurst,
        StPostamble
    } dqs_state_t;

    // DQS pair is {fall, rise}
    localparam logic [1:0] DQS_IDLE   = 2'b00;
    localparam logic [1:0] DQS_TOGGLE = 2'b01;

    localparam int unsigned DEFAULT_MAX_WRLAT  = 15;
    localparam int unsigned DEFAULT_LINE_DEPTH = DEFAULT_MAX_WRLAT + 1;

    function automatic int unsigned line_depth(input int unsigned max_wrlat);
        return max_wrlat + 1;
    endfunction

endpackage

// File: rtl/wrlat_delay_line.sv
// Write-latency shift register of {en, mask, data} with a data tap, an early
// (preamble look-ahead) tap and an OR of the enable bits between them.
module wrlat_delay_line
    import wr_data_path_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = DEFAULT_LINE_DEPTH,
    parameter int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] data_sel,
    input  logic [SEL_W-1:0] early_sel,
    output logic [WIDTH-1:0] data_tap,
    output logic             early_en,
    output logic             window_en,
    output logic             any_en
);

    logic [WIDTH-1:0] line_q [DEPTH];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else if (!i_enable) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign data_tap = line_q[data_sel];
    assign early_en = line_q[early_sel][WIDTH-1];

    // Window is inclusive of both taps so gaps up to the preamble length stay seamless
    always_comb begin
        window_en = 1'b0;
        any_en    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_en = any_en | line_q[i][WIDTH-1];
            if (SEL_W'(i) >= early_sel && SEL_W'(i) <= data_sel) begin
                window_en = window_en | line_q[i][WIDTH-1];
            end
        end
    end

endmodule

// File: rtl/wr_data_path.sv
// DDR5 PHY write data path: delays the DFI write stream by the write latency,
// drives DQ/DM and sequences DQS preamble, burst toggling and postamble.
module wr_data_path
    import wr_data_path_pkg::*;
#(
    parameter int unsigned DEVICE_TYPE = 4,
    parameter int unsigned MAX_WRLAT   = DEFAULT_MAX_WRLAT
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [3:0]                 i_wrlat,
    input  logic [1:0]                 i_pre_len,
    input  logic                       i_post_len,
    input  logic                       dfi_wrdata_en,
    input  logic [2*DEVICE_TYPE-1:0]   dfi_wrdata,
    input  logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask,
    output logic [2*DEVICE_TYPE-1:0]   o_dq,
    output logic [DEVICE_TYPE/4-1:0]   o_dm,
    output logic                       o_dq_oe,
    output logic [1:0]                 o_dqs,
    output logic                       o_dqs_oe,
    output logic                       o_busy
);

    localparam int unsigned DQ_W   = 2 * DEVICE_TYPE;
    localparam int unsigned DM_W   = DEVICE_TYPE / 4;
    localparam int unsigned LINE_W = 1 + DM_W + DQ_W;
    localparam int unsigned DEPTH  = line_depth(MAX_WRLAT);
    localparam int unsigned SEL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]        wrlat_c;
    logic [1:0]        pre_raw;
    logic [1:0]        pre_eff;
    logic [SEL_W-1:0]  data_sel;
    logic [SEL_W-1:0]  early_sel;
    logic [LINE_W-1:0] data_tap;
    logic              early_en;
    logic              window_en;
    logic              any_en;

    always_comb begin
        wrlat_c = (32'(i_wrlat) > MAX_WRLAT) ? 4'(MAX_WRLAT) : i_wrlat;
        pre_raw = (i_pre_len == 2'd0) ? 2'd1 : i_pre_len;
        // Preamble cannot reach further back than the write latency
        pre_eff = ({2'b00, pre_raw} > wrlat_c) ? wrlat_c[1:0] : pre_raw;
        data_sel  = SEL_W'(wrlat_c);
        early_sel = SEL_W'(wrlat_c - {2'b00, pre_eff});
    end

    wrlat_delay_line #(
        .WIDTH (LINE_W),
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_delay_line (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .din       ({dfi_wrdata_en, dfi_wrdata_mask, dfi_wrdata}),
        .data_sel  (data_sel),
        .early_sel (early_sel),
        .data_tap  (data_tap),
        .early_en  (early_en),
        .window_en (window_en),
        .any_en    (any_en)
    );

    logic            tap_en;
    logic [DM_W-1:0] tap_dm;
    logic [DQ_W-1:0] tap_dq;

    assign tap_en = data_tap[LINE_W-1];
    assign tap_dm = data_tap[DQ_W +: DM_W];
    assign tap_dq = data_tap[DQ_W-1:0];

    logic [DQ_W-1:0] dq_q;
    logic [DM_W-1:0] dm_q;
    logic            dq_oe_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            dq_q    <= '0;
            dm_q    <= '0;
            dq_oe_q <= 1'b0;
        end else if (!i_enable) begin
            dq_q    <= '0;
            dm_q    <= '0;
            dq_oe_q <= 1'b0;
        end else begin
            dq_q    <= tap_en ? tap_dq : '0;
            dm_q    <= tap_en ? tap_dm : '0;
            dq_oe_q <= tap_en;
        end
    end

    dqs_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    dqs_state_t start_state;

    // Zero-length preamble goes straight to toggling
    assign start_state = (pre_eff == 2'd0) ? StBurst : StPreamble;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        o_dqs_oe = 1'b0;
        o_dqs    = DQS_IDLE;
        unique case (state_q)
            StIdle: begin
                if (early_en) begin
                    state_d = start_state;
                    cnt_d   = pre_eff;
                end
            end
            StPreamble: begin
                o_dqs_oe = 1'b1;
                o_dqs    = (cnt_q == 2'd1) ? DQS_TOGGLE : DQS_IDLE;
                if (cnt_q <= 2'd1) state_d = StBurst;
                else               cnt_d   = cnt_q - 2'd1;
            end
            StBurst: begin
                o_dqs_oe = 1'b1;
                o_dqs    = DQS_TOGGLE;
                if (!window_en) begin
                    state_d = StPostamble;
                    cnt_d   = {1'b0, i_post_len} + 2'd1;
                end
            end
            StPostamble: begin
                o_dqs_oe = 1'b1;
                if (early_en) begin
                    state_d = start_state;
                    cnt_d   = pre_eff;
                end else if (cnt_q <= 2'd1) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else if (!i_enable) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_dq    = dq_q;
    assign o_dm    = dm_q;
    assign o_dq_oe = dq_oe_q;
    assign o_busy  = any_en | (state_q != StIdle);

endmodule

// File: doc/wr_data_path.md
Name: wr_data_path

Overview:
- Downstream neighbour of the frequency-ratio phase mapper in the DDR5 PHY write path.
- Consumes the single-phase DFI write stream (dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask) and delays it by the programmed PHY write latency.
- Drives DQ/DM with output enables and generates DQS with a programmable preamble and postamble.
- Seamless back-to-back bursts keep DQS toggling with no postamble/preamble in between.

Parameters:
- DEVICE_TYPE, 4, DQ width per device (4/8/16); DQ bus per cycle is 2*DEVICE_TYPE (rise half = low bits, fall half = high bits).
- MAX_WRLAT, 15, largest legal i_wrlat; sets delay-line depth.

Ports:
- i_clock  in  1  PHY clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  block enable; low = synchronous flush.
- i_wrlat  in  4  write latency in PHY cycles (must be >= preamble cycles and <= MAX_WRLAT).
- i_pre_len  in  2  preamble cycles: 1, 2 or 3 (0 treated as 1).
- i_post_len  in  1  postamble cycles: 0 -> 1 cycle, 1 -> 2 cycles.
- dfi_wrdata_en  in  1  write data valid from the phase mapper.
- dfi_wrdata  in  2*DEVICE_TYPE  write data.
- dfi_wrdata_mask  in  DEVICE_TYPE/4  write mask.
- o_dq  out  2*DEVICE_TYPE  DQ rise/fall pair.
- o_dm  out  DEVICE_TYPE/4  data mask.
- o_dq_oe  out  1  DQ/DM output enable.
- o_dqs  out  2  DQS value {fall,rise}.
- o_dqs_oe  out  1  DQS output enable.
- o_busy  out  1  any enable in flight or FSM not IDLE.

Behaviour:
- Reset values: all outputs 0; delay line cleared; FSM in IDLE.
- i_enable=0 on a clock edge: delay line cleared, FSM forced to IDLE, all outputs 0 on that edge.
- Data latency:
  - A beat sampled with dfi_wrdata_en=1 at edge N appears on o_dq/o_dm with o_dq_oe=1 at edge N+i_wrlat+1, for exactly one cycle.
  - Beats with en=0 produce o_dq_oe=0 and o_dq/o_dm=0.
- Early tap: a second tap gives enable delayed to edge N+i_wrlat+1-P, where P = preamble cycles. It drives DQS look-ahead.
- DQS FSM states: IDLE, PREAMBLE, BURST, POSTAMBLE.
- IDLE:
  - o_dqs_oe=0, o_dqs=00.
  - Early-tap en=1 -> PREAMBLE; load counter with P.
- PREAMBLE:
  - o_dqs_oe=1.
  - o_dqs=00 on every cycle except the last, which is 01 (rise high).
  - Counter reaches 1 -> BURST.
- BURST:
  - o_dqs_oe=1, o_dqs=01 every cycle.
  - Stays in BURST while the data tap has en=1, or while any delay-line bit between the early tap and the data tap is 1 (seamless gap). During a gap cycle DQS keeps toggling and o_dq_oe=0.
  - Otherwise -> POSTAMBLE; load counter with i_post_len+1.
- POSTAMBLE:
  - o_dqs_oe=1, o_dqs=00.
  - Early-tap en=1 -> PREAMBLE (postamble aborted, counter reloaded with P).
  - Counter reaches 1 -> IDLE.
- o_busy = OR of all delay-line enable bits, or FSM != IDLE.
- Configuration: i_wrlat, i_pre_len and i_post_len are sampled continuously. They may change only while o_busy=0; behaviour on a change while busy is undefined and not checked.
- Illegal setting i_wrlat < P: P is clamped to i_wrlat (i_wrlat=0 gives no preamble, direct IDLE->BURST).
- Reset asserted mid-burst: all outputs go to 0 immediately (async). The burst is dropped, not resumed.

Decomposition:
- Package wr_data_path_pkg:
  - State enum dqs_state_t (IDLE, PREAMBLE, BURST, POSTAMBLE).
  - Constants DQS_IDLE=2'b00 and DQS_TOGGLE=2'b01.
  - Localparam for delay-line depth.
- Sub-module wrlat_delay_line:
  - Parameterised-width shift register of {en, mask, data}, depth MAX_WRLAT+1.
  - Two variable taps (data tap, early tap) plus an OR of the enable bits between the taps.
  - Sync clear on !i_enable.

Test Plan:
- Reset/idle: release reset, no writes for 20 cycles -> all outputs 0, o_busy=0.
- Single burst, DEVICE_TYPE=4, i_wrlat=4, i_pre_len=2, i_post_len=0; en=1 at edges 0-3 with data 8'hA5, 8'h3C, 8'hF0, 8'h0F ->
  - o_dqs_oe high at edges 3-9: o_dqs 00,01 at 3-4 (preamble); 01 at 5-8; 00 at 9 (postamble).
  - o_dq_oe high at edges 5-8 carrying A5, 3C, F0, 0F.
- Seamless: same config, second burst starts 1 cycle after the first ends -> DQS keeps toggling through the 1-cycle gap with no postamble/preamble; o_dq_oe=0 in the gap cycle only.
- Postamble abort: the second burst's early tap fires during the postamble (i_post_len=1) -> PREAMBLE re-entered immediately; data latency still exactly i_wrlat+1.
- Mid-burst i_enable=0 at edge 6 -> all outputs 0 at edge 6, o_busy=0 after edge 6; a new write afterwards behaves as from reset.
- Latency sweep: i_wrlat 1..15 with i_pre_len 1..3 (legal combinations) -> first o_dq_oe exactly i_wrlat+1 cycles after the first en; preamble length equals P.
